// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Scoreboard entries carry only the fields each stage's checks actually read.
package hazard_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
    logic       regwrite;
    logic [1:0] tnew;
    logic       md_start;
    logic       md_div;
  } e_entry_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wreg;
    logic       regwrite;
    logic [1:0] tnew;
  } m_entry_t;

  typedef struct packed {
    logic [4:0] wreg;
    logic       regwrite;
  } w_entry_t;

  // $0 is hard-wired, so a write to it never produces a usable value.
  function automatic logic reg_hit(input logic regwrite, input logic [4:0] wreg,
                                   input logic [4:0] r);
    return regwrite && (wreg == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Multiply/divide busy counter: loads the op's latency when it leaves E, then counts down.
// o_busy is high while any cycles remain.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);

  logic [3:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 4'd0;
    end else if (i_start) begin
      r_count <= i_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_busy = (r_count != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: scoreboard of E/M/W destinations driving
// stall, E bubble and forwarding selects, plus HI/LO sequencing through md_busy_counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = hazard_pkg::MULT_CYCLES,
  parameter int DIV_CYCLES  = hazard_pkg::DIV_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wreg,
  input  logic       d_regwrite,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic       flush_e,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       fwd_m_rt
);

  import hazard_pkg::*;

  e_entry_t r_e;
  m_entry_t r_m;
  w_entry_t r_w;

  logic w_md_busy;
  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;

  // An operand stalls only if a producer still needs more cycles than the consumer can wait.
  function automatic logic data_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                       input e_entry_t e, input m_entry_t m);
    logic hz;
    hz = 1'b0;
    if (tuse != TUSE_NONE) begin
      if (reg_hit(e.regwrite, e.wreg, r) && (e.tnew > tuse)) hz = 1'b1;
      if (reg_hit(m.regwrite, m.wreg, r) && (m.tnew > tuse)) hz = 1'b1;
    end
    return hz;
  endfunction

  // Nearest ready producer wins; M is usable only once its result is already computed.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input m_entry_t m,
                                         input w_entry_t w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_hit(m.regwrite, m.wreg, r) && (m.tnew == 2'd0)) begin
      sel = FWD_M;
    end else if (reg_hit(w.regwrite, w.wreg, r)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy (
    .clk     (clk),
    .reset   (reset),
    .i_start (r_e.md_start),
    .i_div   (r_e.md_div),
    .o_busy  (w_md_busy)
  );

  always_comb begin
    w_stall_rs = data_hazard(d_rs, d_tuse_rs, r_e, r_m);
    w_stall_rt = data_hazard(d_rt, d_tuse_rt, r_e, r_m);
    // An md op sitting in E has not loaded the counter yet, so it blocks on its own.
    w_stall_md = d_md_use && (w_md_busy || r_e.md_start);
    w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
  end

  always_comb begin
    stall    = w_stall;
    flush_e  = w_stall;
    fwd_d_rs = fwd_sel(d_rs, r_m, r_w);
    fwd_d_rt = fwd_sel(d_rt, r_m, r_w);
    fwd_e_rs = fwd_sel(r_e.rs, r_m, r_w);
    fwd_e_rt = fwd_sel(r_e.rt, r_m, r_w);
    fwd_m_rt = reg_hit(r_w.regwrite, r_w.wreg, r_m.rt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_w.wreg     <= r_m.wreg;
      r_w.regwrite <= r_m.regwrite;

      r_m.rt       <= r_e.rt;
      r_m.wreg     <= r_e.wreg;
      r_m.regwrite <= r_e.regwrite;
      r_m.tnew     <= (r_e.tnew != 2'd0) ? (r_e.tnew - 2'd1) : 2'd0;

      if (w_stall) begin
        r_e <= '0;
      end else begin
        r_e.rs       <= d_rs;
        r_e.rt       <= d_rt;
        r_e.wreg     <= d_wreg;
        r_e.regwrite <= d_regwrite;
        r_e.tnew     <= d_tnew;
        r_e.md_start <= d_md_start;
        r_e.md_div   <= d_md_div;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, store-data, $0, mult/div and reset cases.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wreg;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_regwrite, d_md_start, d_md_div, d_md_use;
  logic       stall, flush_e, fwd_m_rt;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  int total = 0;
  int bad   = 0;
  int n;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wreg     (d_wreg),
    .d_regwrite (d_regwrite),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .stall      (stall),
    .flush_e    (flush_e),
    .fwd_d_rs   (fwd_d_rs),
    .fwd_d_rt   (fwd_d_rt),
    .fwd_e_rs   (fwd_e_rs),
    .fwd_e_rt   (fwd_e_rt),
    .fwd_m_rt   (fwd_m_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                         input logic [4:0] rt, input logic [1:0] tu_rt,
                         input logic [4:0] wreg, input logic rw, input logic [1:0] tnew,
                         input logic mds, input logic mdd, input logic mdu);
    d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
    d_wreg = wreg; d_regwrite = rw; d_tnew = tnew;
    d_md_start = mds; d_md_div = mdd; d_md_use = mdu;
    #1;
  endtask

  task automatic nop();
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    tick(); tick(); tick();
  endtask

  // Counts consecutive stall cycles with the D inputs held, bounded at 20.
  task automatic count_stall(input string tag, output int cnt);
    cnt = 0;
    while (stall === 1'b1 && cnt < 20) begin
      chk({tag, "_flush"}, flush_e, 1);
      cnt++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_d(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush_e, 0);
    chk("rst_fwd_d_rs", fwd_d_rs, 0);
    chk("rst_fwd_d_rt", fwd_d_rt, 0);
    chk("rst_fwd_e_rs", fwd_e_rs, 0);
    chk("rst_fwd_e_rt", fwd_e_rt, 0);
    chk("rst_fwd_m_rt", fwd_m_rt, 0);
    drain();

    // lw $8 then addu using $8 in E (tuse 1): one stall, then W forwards into E
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("lu_lw_nostall", stall, 0);
    tick();
    drive_d(5'd8, 2'd1, 5'd0, 2'd3, 5'd10, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall1", stall, 1);
    chk("lu_flush1", flush_e, 1);
    tick();
    chk("lu_stall2", stall, 0);
    chk("lu_fwd_d_m_notready", fwd_d_rs, 0);
    tick();
    nop();
    chk("lu_fwd_e_rs_w", fwd_e_rs, 2);
    drain();

    // lw $8 then beq on $8 (tuse 0): two stalls
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive_d(5'd0, 2'd3, 5'd8, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    count_stall("lu0", n);
    chk("lu0_stall_cycles", n, 2);
    chk("lu0_fwd_d_rt_w", fwd_d_rt, 2);
    drain();

    // addu $9 then beq on $9: one stall, then M forwards into D
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_d(5'd9, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("br_stall1", stall, 1);
    tick();
    chk("br_stall2", stall, 0);
    chk("br_fwd_d_rs_m", fwd_d_rs, 1);
    tick();
    nop();
    chk("br_fwd_e_rs_w", fwd_e_rs, 2);
    drain();

    // addu $11 then sw with rt=$11: E forward from M, then M store data from W
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd11, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_d(5'd0, 2'd1, 5'd11, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("sw_nostall", stall, 0);
    tick();
    nop();
    chk("sw_fwd_e_rt_m", fwd_e_rt, 1);
    tick();
    chk("sw_fwd_m_rt_w", fwd_m_rt, 1);
    drain();

    // ori $0 then a reader of $0: never stalls, never forwards
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("r0_stall", stall, 0);
    tick();
    chk("r0_fwd_d_rs", fwd_d_rs, 0);
    chk("r0_fwd_e_rs", fwd_e_rs, 0);
    drain();

    // mult then mflo: 1 + 5 stall cycles
    drive_d(5'd4, 2'd3, 5'd5, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("mul_first_nostall", stall, 0);
    tick();
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    count_stall("mul", n);
    chk("mul_stall_cycles", n, 6);
    drain();

    // div then mflo: 1 + 10 stall cycles
    drive_d(5'd4, 2'd3, 5'd5, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    count_stall("div", n);
    chk("div_stall_cycles", n, 11);
    drain();

    // back-to-back mult: the second one waits like any HI/LO user
    drive_d(5'd4, 2'd3, 5'd5, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    tick();
    count_stall("mm", n);
    chk("mm_stall_cycles", n, 6);
    drain();

    // div then mflo, reset three cycles into the busy period
    drive_d(5'd4, 2'd3, 5'd5, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    chk("rmd_busy_before", stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rmd_stall_after", stall, 0);
    chk("rmd_flush_after", flush_e, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. It tracks destination register, write-enable and remaining-latency (Tnew) for the E, M and W stages in its own scoreboard. It uses that scoreboard to drive stall, E-stage bubble and forwarding selects. It also sequences the multi-cycle multiply/divide unit through a busy counter, so that HI/LO instructions in D stall until the unit is free.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after a div/divu leaves E

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- d_rs, d_rt  in  5 each  source registers of the instruction in D
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until operand needed (0..2); 3 = operand unused
- d_wreg  in  5  destination register of the instruction in D
- d_regwrite  in  1  instruction in D writes GPR
- d_tnew  in  2  cycles from E entry until result forwardable (0..2)
- d_md_start  in  1  D instruction is mult/multu/div/divu
- d_md_div  in  1  with d_md_start: 1 = divide
- d_md_use  in  1  D instruction is any HI/LO instruction (mult/div/mfhi/mflo/mthi/mtlo)
- stall  out  1  hold PC and D register
- flush_e  out  1  load bubble into E register; always equals stall
- fwd_d_rs, fwd_d_rt  out  2 each  D operand source: 0 RF, 1 M, 2 W
- fwd_e_rs, fwd_e_rt  out  2 each  E operand source: 0 E register, 1 M, 2 W
- fwd_m_rt  out  1  M store data: 0 M register, 1 W

## Operation
- Scoreboard per stage: E {rs, rt, wreg, regwrite, tnew, md_start, md_div}; M {rt, wreg, regwrite, tnew}; W {wreg, regwrite}.
- The scoreboard advances every cycle:
  - W ← M.
  - M ← E, with tnew = (E.tnew > 0) ? E.tnew−1 : 0.
  - E ← D fields when stall=0.
  - E ← bubble (all fields 0) when stall=1.
- A stage "matches" register r when: regwrite=1, wreg=r, and r≠0.
- Data stall for an operand r with tuse≠3:
  - E matches r and E.tnew > tuse, or
  - M matches r and M.tnew > tuse.
  - stall = data stall on rs OR data stall on rt OR md stall.
- MD stall: d_md_use=1 AND (busy counter ≠ 0 OR E.md_start=1).
- Busy counter (4 bit):
  - When E.md_start=1, it loads DIV_CYCLES if E.md_div=1, else MULT_CYCLES.
  - Otherwise it decrements when nonzero and saturates at 0.
- Forwarding: the nearest stage wins, and only from a stage whose tnew=0.
  - D operand: M (M.tnew=0) > W > RF.
  - E operand: M (M.tnew=0) > W > E register.
  - M rt: W if W matches M.rt.
  - No match on any stage selects 0.
- Register 0 never stalls and never forwards.

## Timing
- Outputs are combinational from the registered scoreboard plus the D inputs. Scoreboard and counter update on the posedge.
- Reset clears every scoreboard field and the counter to 0. After reset, every output is 0 regardless of the D inputs.
- A reset asserted mid-operation (a stall in progress or the counter busy) clears everything in the same edge. The next cycle has stall=0.
- Load-use: lw in E (tnew 2) with a dependent tuse=0 stalls 2 cycles. With tuse=1 it stalls 1 cycle.
- While stalled, the D inputs are held externally. The stall resolves in the cycle the blocking condition clears, with no extra cycle.
- MD sequencing: a mult in E followed by mfhi in D stalls for 1 cycle (E.md_start), then for MULT_CYCLES cycles. mfhi leaves D on cycle MULT_CYCLES+1 after mult entered E.
- Back-to-back mult: the second mult stalls the same way, because it is itself an MD user.
- Simultaneous events:
  - A data stall and an MD stall together produce a single stall.
  - Forwarding selects are valid even while stall=1.

## Structure
- Shared package hazard_pkg holds:
  - TUSE_NONE = 2'd3.
  - Forward encodings FWD_RF/FWD_M/FWD_W.
  - Default cycle counts MULT_CYCLES/DIV_CYCLES.
  - Scoreboard entry struct.
- One sub-module: md_busy_counter, containing the load/decrement counter and the busy output.
- Stall and forward logic stay in hazard_ctrl.

## Test plan
- Reset: drive reset 1 cycle with d_rs=5, d_tuse_rs=0 → stall=0, all fwd=0. Counter=0.
- Load-use: lw $8 (d_tnew=2, wreg 8), then addu with rs=8, tuse_rs=1 → stall=1 for exactly 1 cycle, then fwd_e_rs=2 (W).
- Branch after ALU op: addu $9 (tnew=1), then beq with rs=9, tuse=0 → stall 1 cycle, then fwd_d_rs=1 (M).
- Register 0: ori $0 (tnew 1), then an op with rs=0, tuse=0 → stall=0, fwd_d_rs=0.
- MD: mult followed by mflo → stall asserted 6 consecutive cycles (1+MULT_CYCLES). Repeat with div → 11 cycles.
- Reset mid-MD: assert reset 3 cycles into a div busy period with mflo held in D → stall=0 on the cycle after reset deasserts.
